// File: rtl/test_binop_seq.sv
// Self-checking driver/checker for a two-operand arithmetic DUT: issues an arithmetic
// progression of operand pairs, delays a golden result by LATENCY and scores every y.
module test_binop_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned LATENCY = 0,
    parameter int unsigned OP      = 0,
    parameter int unsigned A0      = 9,
    parameter int unsigned B0      = 3,
    parameter int unsigned A_STEP  = 1,
    parameter int unsigned B_STEP  = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             fail,
    output logic             finish,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    localparam int unsigned IW = 16;
    localparam int unsigned CW = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VEC - 1);
    localparam logic [IW-1:0] NO_ERR   = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] exp;
    } chk_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    drain_q, drain_d;
    logic             fail_q, fail_d, finish_q, finish_d;
    logic [15:0]      err_q, err_d, first_q, first_d;
    logic [WIDTH-1:0] exp_c;
    chk_t             issue_c, chk_c;
    logic             mism_c;

    // Golden result for the operands currently on a/b
    always_comb begin
        exp_c = WIDTH'(a_q * b_q);
        if (OP == 1) begin
            exp_c = a_q + b_q;
        end else if (OP == 2) begin
            exp_c = a_q - b_q;
        end
    end

    always_comb begin
        issue_c       = '0;
        issue_c.valid = (state_q == ST_RUN);
        issue_c.idx   = idx_q;
        issue_c.exp   = exp_c;
    end

    // Align the golden result with the DUT's pipeline latency
    if (LATENCY == 0) begin : g_comb
        assign chk_c = issue_c;
    end else begin : g_pipe
        chk_t [LATENCY-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d    = pipe_q;
            pipe_d[0] = issue_c;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign chk_c = pipe_q[LATENCY-1];
    end

    assign mism_c = chk_c.valid && (state_q != ST_DONE) && (y != chk_c.exp);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        fail_d   = fail_q | mism_c;
        finish_d = finish_q;
        err_d    = err_q;
        first_d  = first_q;

        if (mism_c) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            if (first_q == NO_ERR) begin
                first_d = chk_c.idx;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    drain_d = '0;
                    if (LATENCY == 0) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                    a_d   = a_q + WIDTH'(A_STEP);
                    b_d   = b_q + WIDTH'(B_STEP);
                end
            end
            ST_DRAIN: begin
                // Last in-flight vector is checked on the edge that leaves DRAIN
                if (drain_q == CW'(LATENCY - 1)) begin
                    state_d  = ST_DONE;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            a_q      <= WIDTH'(A0);
            b_q      <= WIDTH'(B0);
            idx_q    <= '0;
            drain_q  <= '0;
            fail_q   <= 1'b0;
            finish_q <= 1'b0;
            err_q    <= '0;
            first_q  <= NO_ERR;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            fail_q   <= fail_d;
            finish_q <= finish_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    assign a             = a_q;
    assign b             = b_q;
    assign fail          = fail_q;
    assign finish        = finish_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_test_binop_seq.sv
// Bench for test_binop_seq: nine checker instances against small behavioural DUTs,
// with expected end-of-run records scored when each instance raises finish.
module tb_test_binop_seq;

    localparam int NI = 9;

    typedef struct {
        int inst;
        int cyc;
        int fl;
        int ec;
        int fe;
    } rec_t;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic rst7   = 1'b0;
    logic mon_en = 1'b0;
    logic rst8;

    logic [7:0]  a_w [NI];
    logic [7:0]  b_w [NI];
    logic [7:0]  y_w [NI];
    logic        fail_w [NI];
    logic        fin_w [NI];
    logic [15:0] ec_w [NI];
    logic [15:0] fe_w [NI];
    bit          fin_prev [NI];

    logic [7:0] s1_6, s2_6, s1_7, s2_7;
    int cnt, cnt7;
    int total = 0;
    int bad   = 0;

    rec_t        exp_q[$];
    logic [15:0] ab_q[$];

    always #5 clock = ~clock;

    assign rst8 = reset | rst7;

    // Behavioural DUTs: constants, comb multipliers, a single-vector fault, 2-stage multipliers
    assign y_w[0] = 8'd144;
    assign y_w[1] = 8'd202;
    assign y_w[2] = 8'd198;
    assign y_w[3] = 8'(a_w[3] * b_w[3]);
    assign y_w[4] = 8'd0;
    assign y_w[5] = 8'(a_w[5] * b_w[5]) + 8'(a_w[5] == 8'd16);
    assign y_w[6] = s2_6;
    assign y_w[7] = s2_7;
    assign y_w[8] = 8'd0;

    always @(posedge clock) begin
        s1_6 <= 8'(a_w[6] * b_w[6]);
        s2_6 <= s1_6;
        s1_7 <= 8'(a_w[7] * b_w[7]);
        s2_7 <= s1_7;
        cnt  <= reset ? 0 : cnt + 1;
        cnt7 <= rst8 ? 0 : cnt7 + 1;
    end

    test_binop_seq #(.A0(200), .B0(2), .NUM_VEC(1), .OP(0)) u_mul1 (
        .clock(clock), .reset(reset), .a(a_w[0]), .b(b_w[0]), .y(y_w[0]),
        .fail(fail_w[0]), .finish(fin_w[0]), .err_count(ec_w[0]), .first_err_idx(fe_w[0]));
    test_binop_seq #(.A0(200), .B0(2), .NUM_VEC(1), .OP(1)) u_add1 (
        .clock(clock), .reset(reset), .a(a_w[1]), .b(b_w[1]), .y(y_w[1]),
        .fail(fail_w[1]), .finish(fin_w[1]), .err_count(ec_w[1]), .first_err_idx(fe_w[1]));
    test_binop_seq #(.A0(200), .B0(2), .NUM_VEC(1), .OP(2)) u_sub1 (
        .clock(clock), .reset(reset), .a(a_w[2]), .b(b_w[2]), .y(y_w[2]),
        .fail(fail_w[2]), .finish(fin_w[2]), .err_count(ec_w[2]), .first_err_idx(fe_w[2]));
    test_binop_seq u_good (
        .clock(clock), .reset(reset), .a(a_w[3]), .b(b_w[3]), .y(y_w[3]),
        .fail(fail_w[3]), .finish(fin_w[3]), .err_count(ec_w[3]), .first_err_idx(fe_w[3]));
    test_binop_seq u_zero (
        .clock(clock), .reset(reset), .a(a_w[4]), .b(b_w[4]), .y(y_w[4]),
        .fail(fail_w[4]), .finish(fin_w[4]), .err_count(ec_w[4]), .first_err_idx(fe_w[4]));
    test_binop_seq u_vec7 (
        .clock(clock), .reset(reset), .a(a_w[5]), .b(b_w[5]), .y(y_w[5]),
        .fail(fail_w[5]), .finish(fin_w[5]), .err_count(ec_w[5]), .first_err_idx(fe_w[5]));
    test_binop_seq #(.LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .a(a_w[6]), .b(b_w[6]), .y(y_w[6]),
        .fail(fail_w[6]), .finish(fin_w[6]), .err_count(ec_w[6]), .first_err_idx(fe_w[6]));
    test_binop_seq #(.LATENCY(2)) u_lat2 (
        .clock(clock), .reset(reset), .a(a_w[7]), .b(b_w[7]), .y(y_w[7]),
        .fail(fail_w[7]), .finish(fin_w[7]), .err_count(ec_w[7]), .first_err_idx(fe_w[7]));
    test_binop_seq u_rst (
        .clock(clock), .reset(rst8), .a(a_w[8]), .b(b_w[8]), .y(y_w[8]),
        .fail(fail_w[8]), .finish(fin_w[8]), .err_count(ec_w[8]), .first_err_idx(fe_w[8]));

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push_rec(input int inst, input int cyc, input int fl, input int ec, input int fe);
        rec_t r;
        r.inst = inst;
        r.cyc  = cyc;
        r.fl   = fl;
        r.ec   = ec;
        r.fe   = fe;
        exp_q.push_back(r);
    endtask

    // Monitor: operand stream of u_good every cycle, end-of-run record on each finish rise
    always @(negedge clock) begin
        if (mon_en) begin
            if (ab_q.size() > 0) begin
                logic [15:0] ab;
                ab = ab_q.pop_front();
                chk("good_a", longint'(a_w[3]), longint'(ab[15:8]));
                chk("good_b", longint'(b_w[3]), longint'(ab[7:0]));
            end
            for (int i = 0; i < NI; i++) begin
                if (fin_w[i] && !fin_prev[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_finish", longint'(i), -1);
                    end else begin
                        rec_t r;
                        int   c;
                        r = exp_q.pop_front();
                        c = (i == 8) ? cnt7 - 1 : cnt - 1;
                        chk($sformatf("u%0d_finish_order", i), longint'(i), longint'(r.inst));
                        chk($sformatf("u%0d_finish_cycle", i), longint'(c), longint'(r.cyc));
                        chk($sformatf("u%0d_fail", i), longint'(fail_w[i]), longint'(r.fl));
                        chk($sformatf("u%0d_err_count", i), longint'(ec_w[i]), longint'(r.ec));
                        chk($sformatf("u%0d_first_err", i), longint'(fe_w[i]), longint'(r.fe));
                    end
                end
                fin_prev[i] = fin_w[i];
            end
        end
    end

    initial begin
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("rst_a", longint'(a_w[3]), 9);
        chk("rst_b", longint'(b_w[3]), 3);
        chk("rst_fail", longint'(fail_w[3]), 0);
        chk("rst_finish", longint'(fin_w[3]), 0);
        chk("rst_err_count", longint'(ec_w[3]), 0);
        chk("rst_first_err", longint'(fe_w[3]), 65535);
        chk("rst_a_200", longint'(a_w[0]), 200);
        chk("rst_b_2", longint'(b_w[0]), 2);

        // Finish order: single-vector tests, 16-vector comb tests, latency 1, latency 2, rerun
        push_rec(0, 0, 0, 0, 65535);
        push_rec(1, 0, 0, 0, 65535);
        push_rec(2, 0, 0, 0, 65535);
        push_rec(3, 15, 0, 0, 65535);
        push_rec(4, 15, 1, 16, 0);
        push_rec(5, 15, 1, 1, 7);
        push_rec(6, 16, 1, 15, 1);
        push_rec(7, 17, 0, 0, 65535);
        push_rec(8, 15, 1, 16, 0);
        for (int k = 0; k < 18; k++) begin
            int kk;
            kk = (k > 15) ? 15 : k;
            ab_q.push_back({8'(9 + kk), 8'(3 + 2 * kk)});
        end

        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int t = 0; t < 100 && cnt != 5; t++) @(negedge clock);
        chk("reach_cycle5", longint'(cnt), 5);
        chk("rst_pre_fail", longint'(fail_w[8]), 1);
        chk("rst_pre_err_count", longint'(ec_w[8]), 5);
        rst7 = 1'b1;
        @(negedge clock);
        rst7 = 1'b0;
        chk("rst_mid_fail", longint'(fail_w[8]), 0);
        chk("rst_mid_err_count", longint'(ec_w[8]), 0);
        chk("rst_mid_first_err", longint'(fe_w[8]), 65535);
        chk("rst_mid_finish", longint'(fin_w[8]), 0);
        chk("rst_mid_a", longint'(a_w[8]), 9);
        chk("rst_mid_b", longint'(b_w[8]), 3);

        repeat (40) @(negedge clock);
        chk("records_left", longint'(exp_q.size()), 0);
        chk("operands_left", longint'(ab_q.size()), 0);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_finish_sticky", i), longint'(fin_w[i]), 1);
        end
        chk("zero_err_frozen", longint'(ec_w[4]), 16);
        chk("good_a_hold", longint'(a_w[3]), 24);
        chk("good_b_hold", longint'(b_w[3]), 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
